// File: rtl/async_lib_pkg.sv
// rtl/async_lib_pkg.sv - shared types for the async_lib CDC counter links
package async_lib_pkg;

    // Transmit-side flush sequencing
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } async_tx_state_e;

    // Smallest legal synchroniser depth
    localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/async_sync_chain.sv
// rtl/async_sync_chain.sv - multi-bit flop chain synchroniser with async reset
module async_sync_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the asynchronous input through STAGES flops; only gray-coded
    // buses are fed in, so a bus-wide sample sees at most one bit in motion
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/comb_binary2gray.sv
// rtl/comb_binary2gray.sv - combinational binary to gray converter
module comb_binary2gray #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    // Adjacent binary values map to codes differing in a single bit
    always_comb begin
        gray_o = bin_i ^ (bin_i >> 1);
    end

endmodule

// File: rtl/comb_gray2binary.sv
// rtl/comb_gray2binary.sv - combinational gray to binary converter
module comb_gray2binary #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all gray bits at or above it
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/async_counter_sender.sv
// rtl/async_counter_sender.sv - source end of a gray-coded event-count crossing
module async_counter_sender
    import async_lib_pkg::*;
#(
    parameter int COUNTER_LEN     = 4,
    parameter int MAX_OUTSTANDING = 2**COUNTER_LEN,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   evt_valid_i,
    output logic                   evt_ready_o,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic [COUNTER_LEN:0]   cnt_gray_o,
    input  logic [COUNTER_LEN:0]   ack_gray_i,
    output logic [COUNTER_LEN:0]   outstanding_o,
    output logic                   err_o
);

    localparam int CW = COUNTER_LEN + 1;
    localparam logic [CW-1:0] MAX_W = CW'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 2**COUNTER_LEN) begin : g_bad_max
        $error("async_counter_sender: MAX_OUTSTANDING out of range 1..2**COUNTER_LEN");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("async_counter_sender: SYNC_STAGES must be at least 2");
    end

    async_tx_state_e state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_gray_q, cnt_gray_d;
    logic [CW-1:0]   ack_sync;
    logic [CW-1:0]   ack_bin_new;
    logic [CW-1:0]   ack_bin_q;
    logic [CW-1:0]   ack_delta;
    logic [CW-1:0]   outstanding;
    logic            err_q, err_d;
    logic            flush_done_q, flush_done_d;
    logic            acc;

    async_sync_chain #(
        .WIDTH  (CW),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .reset_i (reset_i),
        .d_i     (ack_gray_i),
        .q_o     (ack_sync)
    );

    comb_gray2binary #(.WIDTH(CW)) u_ack_g2b (
        .gray_i (ack_sync),
        .bin_o  (ack_bin_new)
    );

    comb_binary2gray #(.WIDTH(CW)) u_cnt_b2g (
        .bin_i  (cnt_d),
        .gray_o (cnt_gray_d)
    );

    // Modular difference copes with either counter having wrapped
    assign outstanding = cnt_q - ack_bin_q;

    // Ready looks only at flops; a stale ack can only under-report credit
    assign evt_ready_o = (state_q == ST_RUN) && (outstanding < MAX_W) && !err_q && !reset_i;

    // Count accepted events and flag an ack that claims more than was sent
    always_comb begin
        acc       = evt_valid_i && evt_ready_o;
        cnt_d     = cnt_q + {{(CW-1){1'b0}}, acc};
        ack_delta = ack_bin_new - ack_bin_q;
        err_d     = err_q || (ack_delta > outstanding);
    end

    // Flush sequencing: drain until every sent event is acked, then pulse done once
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outstanding == '0 && !err_q) begin
                    state_d      = ST_DONE;
                    flush_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!flush_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, counters and the registered gray pointer all move on the same edge
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            cnt_gray_q   <= '0;
            ack_bin_q    <= '0;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cnt_gray_q   <= cnt_gray_d;
            ack_bin_q    <= ack_bin_new;
            err_q        <= err_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign cnt_gray_o    = cnt_gray_q;
    assign outstanding_o = outstanding;
    assign err_o         = err_q;
    assign flush_done_o  = flush_done_q;

endmodule

// File: tb/tb_async_counter_sender.sv
// tb/tb_async_counter_sender.sv - scoreboard bench for async_counter_sender
module tb_async_counter_sender;

    localparam int CL  = 4;
    localparam int CW  = CL + 1;
    localparam int MAX = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          evt_valid_i;
    logic          evt_ready_o;
    logic          flush_i;
    logic          flush_done_o;
    logic [CW-1:0] cnt_gray_o;
    logic [CW-1:0] ack_gray_i;
    logic [CW-1:0] outstanding_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int sent     = 0;
    int accepts  = 0;
    int done_pulses = 0;
    logic [CW-1:0] exp_q [$];
    logic [CW-1:0] prev_gray = '0;

    always #5 clk = ~clk;

    async_counter_sender #(
        .COUNTER_LEN     (CL),
        .MAX_OUTSTANDING (MAX),
        .SYNC_STAGES     (2)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .evt_valid_i   (evt_valid_i),
        .evt_ready_o   (evt_ready_o),
        .flush_i       (flush_i),
        .flush_done_o  (flush_done_o),
        .cnt_gray_o    (cnt_gray_o),
        .ack_gray_i    (ack_gray_i),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    function automatic logic [CW-1:0] gray(input int n);
        logic [CW-1:0] b;
        b = CW'(n % (1 << CW));
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every change of the gray pointer must match the next queued count
    always @(negedge clk) begin
        if (!reset_i) begin
            if (cnt_gray_o !== prev_gray) begin
                check("gray_step_hamming", $countones(cnt_gray_o ^ prev_gray), 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL gray_unexpected: got %0d with no accept pending", cnt_gray_o);
                end else begin
                    check("gray_value", cnt_gray_o, exp_q.pop_front());
                end
                prev_gray = cnt_gray_o;
            end
            if (flush_done_o) done_pulses++;
        end
    end

    // One clock cycle from negedge to negedge; the accept is decided by the model
    task automatic tick(input logic v);
        logic acc;
        evt_valid_i = v;
        #1;
        acc = v && evt_ready_o;
        @(posedge clk);
        if (acc) begin
            sent++;
            accepts++;
            exp_q.push_back(gray(sent));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        evt_valid_i = 1'b0;
        flush_i     = 1'b0;
        ack_gray_i  = '0;
        @(negedge clk);
        @(negedge clk);
        sent = 0;
        exp_q.delete();
        prev_gray = '0;
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int zero_at;
        int pulse_at;
        int guard;

        // 1: fill credit with ack frozen at 0
        do_reset();
        reset_i = 1'b1;
        #1;
        check("rst_ready", evt_ready_o, 0);
        check("rst_gray", cnt_gray_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_err", err_o, 0);
        check("rst_flush_done", flush_done_o, 0);
        @(negedge clk);
        reset_i = 1'b0;
        accepts = 0;
        repeat (20) tick(1'b1);
        check("fill_accepts", accepts, 16);
        check("fill_gray", cnt_gray_o, 5'b11000);
        check("fill_ready", evt_ready_o, 0);
        check("fill_outstanding", outstanding_o, 16);

        // 2: return 4 credits
        ack_gray_i = gray(4);
        tick(1'b0);
        tick(1'b0);
        check("ack_latency_pre", outstanding_o, 16);
        tick(1'b0);
        check("ack_latency_post", outstanding_o, 12);
        check("ack_ready", evt_ready_o, 1);
        accepts = 0;
        repeat (8) tick(1'b1);
        check("refill_accepts", accepts, 4);
        check("refill_ready", evt_ready_o, 0);
        check("refill_gray", cnt_gray_o, gray(20));

        // 3: wrap with random offers and the receiver acking three behind
        do_reset();
        guard = 0;
        while (sent < 40 && guard < 400) begin
            ack_gray_i = gray((sent >= 3) ? sent - 3 : 0);
            tick(1'($urandom_range(0, 1)));
            guard++;
        end
        check("wrap_sent", sent, 40);
        check("wrap_gray", cnt_gray_o, 5'b01100);
        check("wrap_err", err_o, 0);
        ack_gray_i = gray(sent);
        repeat (4) tick(1'b0);
        check("wrap_drained", outstanding_o, 0);

        // 4: flush with five outstanding
        do_reset();
        repeat (4) tick(1'b1);
        flush_i = 1'b1;
        tick(1'b1);
        flush_i = 1'b0;
        check("flush_sent", sent, 5);
        check("flush_ready_drop", evt_ready_o, 0);
        accepts = 0;
        repeat (4) tick(1'b1);
        check("drain_no_accept", accepts, 0);
        check("drain_outstanding", outstanding_o, 5);
        done_pulses = 0;
        zero_at  = -1;
        pulse_at = -1;
        ack_gray_i = gray(5);
        for (int c = 1; c <= 12; c++) begin
            tick(1'b0);
            if (zero_at < 0 && outstanding_o == 0) zero_at = c;
            if (pulse_at < 0 && flush_done_o) pulse_at = c;
        end
        check("drain_zero_latency", zero_at, 3);
        check("flush_done_timing", pulse_at, zero_at + 1);
        check("flush_done_once", done_pulses, 1);
        check("flush_back_to_run", evt_ready_o, 1);

        // 5: ack runs ahead of the sent count
        do_reset();
        repeat (3) tick(1'b1);
        ack_gray_i = gray(sent + 2);
        repeat (3) tick(1'b0);
        check("err_set", err_o, 1);
        check("err_ready", evt_ready_o, 0);
        accepts = 0;
        repeat (6) tick(1'b1);
        check("err_no_accept", accepts, 0);
        check("err_sticky", err_o, 1);
        do_reset();
        #1;
        check("err_cleared", err_o, 0);
        @(negedge clk);

        // 6: asynchronous reset between edges in the middle of a burst
        repeat (5) tick(1'b1);
        evt_valid_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        check("mid_rst_gray", cnt_gray_o, 0);
        check("mid_rst_outstanding", outstanding_o, 0);
        check("mid_rst_ready", evt_ready_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_flush_done", flush_done_o, 0);
        sent = 0;
        exp_q.delete();
        prev_gray = '0;
        ack_gray_i = '0;
        @(negedge clk);
        reset_i = 1'b0;
        accepts = 0;
        repeat (6) tick(1'b1);
        check("resume_accepts", accepts, 6);
        check("resume_gray", cnt_gray_o, gray(6));
        tick(1'b0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
